// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full adder cell stepped LSB-first under a start/busy/done handshake.
// Optional macro SERIAL_ADDER_SUB_EN turns sub=1 into a - b (B inverted, carry-in forced to 1).

module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] ps_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;

  logic [WIDTH-1:0] b_load_s;
  logic             carry_load_s;
  logic             fa_sum_s;
  logic             fa_co_s;

  fulladder fulladder_inst (
    .a  (a_sh_r[0]),
    .b  (b_sh_r[0]),
    .ci (carry_r),
    .s  (fa_sum_s),
    .co (fa_co_s)
  );

`ifdef SERIAL_ADDER_SUB_EN
  // Operand B and carry seed at the accepting edge; subtraction is a + ~b + 1.
  always_comb begin
    b_load_s     = b;
    carry_load_s = cin;
    if (sub) begin
      b_load_s     = ~b;
      carry_load_s = 1'b1;
    end else begin
      b_load_s     = b;
      carry_load_s = cin;
    end
  end
`else
  logic sub_unused_s;
  assign sub_unused_s = sub;

  // Operand B and carry seed at the accepting edge; plain addition only.
  always_comb begin
    b_load_s     = b;
    carry_load_s = cin;
  end
`endif

  // Control FSM and datapath; sum/cout change only on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      ps_r    <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b_load_s;
            carry_r <= carry_load_s;
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          ps_r    <= {fa_sum_s, ps_r[WIDTH-1:1]};
          carry_r <= fa_co_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            sum     <= {fa_sum_s, ps_r[WIDTH-1:1]};
            cout    <= fa_co_s;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            busy    <= 1'b1;
            done    <= 1'b0;
            state_r <= RUN;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: timeline model compared every cycle plus literal results.
// Honours SERIAL_ADDER_SUB_EN the same way as the design.

module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             cin   = 1'b0;
  logic             sub   = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int errors = 0;
  int checks = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH:0] model_result(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                  input logic c, input logic s);
`ifdef SERIAL_ADDER_SUB_EN
    if (s) return {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
`endif
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  // Timeline model: phase 0 idle, 1..WIDTH busy, WIDTH+1 done.
  int               phase   = 0;
  logic [WIDTH:0]   pending = '0;
  logic [WIDTH:0]   exp_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   = 0;
      pending = '0;
      exp_res = '0;
    end else if (phase == 0) begin
      if (start) begin
        phase   = 1;
        pending = model_result(a, b, cin, sub);
      end
    end else if (phase == WIDTH) begin
      phase   = WIDTH + 1;
      exp_res = pending;
    end else if (phase == WIDTH + 1) begin
      phase = 0;
    end else begin
      phase = phase + 1;
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", 32'(busy), 32'(phase >= 1 && phase <= WIDTH));
    check("cyc_done", 32'(done), 32'(phase == WIDTH + 1));
    check("cyc_sum",  32'(sum),  32'(exp_res[WIDTH-1:0]));
    check("cyc_cout", 32'(cout), 32'(exp_res[WIDTH]));
  end

  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc,
                        input logic ts, input logic [WIDTH-1:0] es, input logic ec, input bit poke);
    int n;
    int bc;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb_v; cin = ~tc; sub = ~ts;
    n = 0;
    bc = 0;
    while (!done && n < 4 * WIDTH) begin
      if (busy) bc++;
      if (poke && n == 2) begin
        start = 1'b1; a = 8'h11; b = 8'h22;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    sub   = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: no done within %0d cycles for a=%0h b=%0h", 4 * WIDTH, ta, tb_v);
    end else begin
      check("op_sum",         32'(sum),  32'(es));
      check("op_cout",        32'(cout), 32'(ec));
      check("op_busy_cycles", 32'(bc),   32'(WIDTH));
    end
  endtask

  initial begin
    int dn;
    int last;

    // Asynchronous reset, checked without a clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_sum",  32'(sum),  32'h0);
    check("rst_cout", 32'(cout), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    run_op(8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);

    // start during RUN must be ignored.
    run_op(8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("poke_idle_busy", 32'(busy), 32'h0);

    // start held high: one result every WIDTH+2 cycles.
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
    dn = 0;
    last = 0;
    for (int i = 1; i <= 3 * (WIDTH + 2); i++) begin
      @(negedge clk);
      if (done) begin
        if (dn > 0) check("b2b_gap", 32'(i - last), 32'(WIDTH + 2));
        last = i;
        dn++;
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(dn),  32'd3);
    check("b2b_sum",   32'(sum), 32'h03);

    // Reset while the counter is at bit 4.
    @(negedge clk);
    a = 8'h55; b = 8'h66; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_sum",  32'(sum),  32'h0);
    check("midrst_cout", 32'(cout), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (WIDTH + 2) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'h0);
    end
    run_op(8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);
    run_op(8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
`else
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
